boundary_column_dispatcher: RTL and testbench

Producer side of the column-reduction interface. It reads boundary-matrix columns from a synchronous SRAM and hands them to a bank of `NUM_UNITS` reduction lanes, one column at a time per lane. Each lane uses a valid/ready handshake. The block sits between the boundary-matrix store and the parallel reduction engine. It drives the engine's `column_data`, `column_addr` and `column_valid` inputs and signals when a batch has been fully consumed.

---
 rtl/boundary_column_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_boundary_column_dispatcher.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_column_dispatcher.sv
// boundary_column_dispatcher
//   Reads boundary-matrix columns from a synchronous SRAM and deals them out
//   round-robin to NUM_UNITS reduction lanes, one column per lane at a time,
//   each lane with its own valid/ready handshake.
//
// Ports
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a batch (sampled in IDLE only)
//   base_addr         : first column address of the batch
//   num_columns       : columns in the batch (0 = empty batch)
//   mem_rd_en/addr    : SRAM read strobe/address (combinational)
//   mem_rd_data       : SRAM data, valid one cycle after mem_rd_en
//   column_data/addr  : per-lane column word / matrix address (lane k at slice k)
//   column_valid      : per-lane valid
//   column_ready      : per-lane ready from the reduction engine
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse at batch end
//   columns_sent      : handshakes completed since the last accepted start

// One lane holding register. A load always wins over a same-edge drain, so a
// lane that is freed and refilled on one edge stays valid.
module boundary_column_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      addr  <= load_addr;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module boundary_column_dispatcher #(
  parameter int NUM_UNITS  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH-1:0]            num_columns,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]  column_data,
  output logic [NUM_UNITS*ADDR_WIDTH-1:0]  column_addr,
  output logic [NUM_UNITS-1:0]             column_valid,
  input  logic [NUM_UNITS-1:0]             column_ready,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH-1:0]            columns_sent
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]      ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] sent;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [ADDR_WIDTH-1:0] xfer_cnt;
  logic                  lane_free;
  logic                  rd_en;

  logic [NUM_UNITS-1:0]                 lane_valid;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] lane_data;
  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_UNITS-1:0]                 xfer;

  // base+idx wraps naturally in ADDR_WIDTH bits.
  assign cur_addr  = base + idx;
  assign idx_inc   = idx + ADDR_WIDTH'(1);
  assign xfer      = lane_valid & column_ready;
  // A lane draining on this edge counts as free, so it can be reissued
  // back-to-back without a bubble.
  assign lane_free = !lane_valid[ptr] || column_ready[ptr];

  always_comb begin
    xfer_cnt = '0;
    for (int k = 0; k < NUM_UNITS; k++) xfer_cnt = xfer_cnt + ADDR_WIDTH'(xfer[k]);
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_columns != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (lane_free) begin
                 rd_en     = 1'b1;
                 state_nxt = S_WAIT;
               end
      S_WAIT:  state_nxt = (idx_inc == count) ? S_DRAIN : S_FETCH;
      S_DRAIN: if (lane_valid == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      idx   <= '0;
      base  <= '0;
      count <= '0;
      sent  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start && num_columns != '0) begin
        base  <= base_addr;
        count <= num_columns;
      end
      if (state == S_WAIT) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        idx <= idx_inc;
      end else if (state == S_DONE) begin
        ptr <= '0;
        idx <= '0;
      end
      // Lanes are all empty in IDLE, so clearing here loses no transfers.
      if (state == S_IDLE && start) sent <= '0;
      else                          sent <= sent + xfer_cnt;
    end
  end

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
    boundary_column_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state == S_WAIT && ptr == PTR_W'(k)),
      .load_data (mem_rd_data),
      .load_addr (cur_addr),
      .ready     (column_ready[k]),
      .data      (lane_data[k]),
      .addr      (lane_addr[k]),
      .valid     (lane_valid[k])
    );
  end

  assign mem_rd_en    = rd_en;
  assign mem_rd_addr  = rd_en ? cur_addr : '0;
  assign column_data  = lane_data;
  assign column_addr  = lane_addr;
  assign column_valid = lane_valid;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign columns_sent = sent;
endmodule

// File: tb/tb_boundary_column_dispatcher.sv
// Self-checking bench for boundary_column_dispatcher: a vector table for
// latency/basic batches, hand-written corner sequences, and randomized
// batches with random backpressure, all checked by a transaction scoreboard
// (expected columns per lane in order, expected SRAM reads in order).
module tb_boundary_column_dispatcher;
  localparam int NU = 8;
  localparam int DW = 16;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     num_columns;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic [NU*DW-1:0]  column_data;
  logic [NU*AW-1:0]  column_addr;
  logic [NU-1:0]     column_valid;
  logic [NU-1:0]     column_ready;
  logic              busy;
  logic              done;
  logic [AW-1:0]     columns_sent;

  boundary_column_dispatcher #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_columns(num_columns), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .column_data(column_data), .column_addr(column_addr),
    .column_valid(column_valid), .column_ready(column_ready), .busy(busy),
    .done(done), .columns_sent(columns_sent)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {4'h0, a} ^ 16'hA5A5;
  endfunction

  // Synchronous SRAM: data one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);

  // Ready source: manual pattern or a fresh random pattern every cycle.
  logic          ready_mode = 1'b0;
  logic [NU-1:0] ready_man  = '1;
  logic [NU-1:0] rnd_ready  = '1;
  always @(posedge clk) begin #1; rnd_ready = NU'($urandom); end
  assign column_ready = ready_mode ? rnd_ready : ready_man;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef logic [AW+DW-1:0] ent_t;
  ent_t           lq[NU][$];
  logic [AW-1:0]  rdq[$];
  logic [AW-1:0]  model_sent = '0;
  logic           mon_en = 1'b0;
  logic [NU-1:0]  prev_hold = '0;
  logic [NU*DW-1:0] prev_data;
  logic [NU*AW-1:0] prev_addr;
  int             mon_n;
  ent_t           mon_e;

  task automatic clear_model();
    for (int k = 0; k < NU; k++) lq[k].delete();
    rdq.delete();
    prev_hold  = '0;
    model_sent = '0;
  endtask

  always @(negedge clk) if (mon_en) begin
    if (mem_rd_en) begin
      if (rdq.size() == 0) check("rd_unexpected", 64'(mem_rd_addr), 64'hFFFF_FFFF);
      else check("rd_addr", 64'(mem_rd_addr), 64'(rdq.pop_front()));
    end else begin
      check("rd_addr_idle", 64'(mem_rd_addr), 64'h0);
    end
    mon_n = 0;
    for (int k = 0; k < NU; k++) begin
      if (prev_hold[k]) begin
        check("hold_valid", 64'(column_valid[k]), 64'h1);
        check("hold_data", 64'(column_data[k*DW +: DW]), 64'(prev_data[k*DW +: DW]));
        check("hold_addr", 64'(column_addr[k*AW +: AW]), 64'(prev_addr[k*AW +: AW]));
      end
      if (column_valid[k] && column_ready[k]) begin
        mon_n++;
        if (lq[k].size() == 0) check("xfer_unexpected", 64'(k), 64'hFF);
        else begin
          mon_e = lq[k].pop_front();
          check("xfer_addr", 64'(column_addr[k*AW +: AW]), 64'(mon_e[AW+DW-1:DW]));
          check("xfer_data", 64'(column_data[k*DW +: DW]), 64'(mon_e[DW-1:0]));
        end
      end
    end
    check("columns_sent", 64'(columns_sent), 64'(model_sent));
    model_sent = model_sent + AW'(mon_n);
    prev_hold  = column_valid & ~column_ready;
    prev_data  = column_data;
    prev_addr  = column_addr;
  end

  // ---------------- helpers ----------------
  // Pushes the expected reads/lane contents, then presents start for one
  // edge; returns #1 after the edge that accepted it.
  task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      rdq.push_back(b + AW'(i));
      lq[i % NU].push_back({b + AW'(i), mem_word(b + AW'(i))});
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_columns = n;
    @(posedge clk); #1;
    start = 1'b0;
    model_sent = '0;
  endtask

  task automatic wait_done(input logic [AW-1:0] exp_sent);
    bit seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("sent_at_done", 64'(columns_sent), 64'(exp_sent));
        check("valid_at_done", 64'(column_valid), 64'h0);
        check("busy_at_done", 64'(busy), 64'h1);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'h0);
        check("busy_after", 64'(busy), 64'h0);
      end
    end
    if (!seen) check("done_timeout", 64'h0, 64'h1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    logic          v0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;
    logic [AW-1:0] sent;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{base:12'h010, num:12'd3, v0:1'b1, d0:16'hA5B5, a0:12'h010, sent:12'd3};
    vecs[1] = '{base:12'hFFE, num:12'd4, v0:1'b1, d0:16'hAA5B, a0:12'hFFE, sent:12'd4};
    vecs[2] = '{base:12'h000, num:12'd0, v0:1'b0, d0:16'h0000, a0:12'h000, sent:12'd0};
    vecs[3] = '{base:12'h123, num:12'd9, v0:1'b1, d0:16'hA486, a0:12'h123, sent:12'd9};
    vecs[4] = '{base:12'h7FF, num:12'd1, v0:1'b1, d0:16'hA25A, a0:12'h7FF, sent:12'd1};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_columns = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 64'(mem_rd_en), 64'h0);
    check("rst_rd_addr", 64'(mem_rd_addr), 64'h0);
    check("rst_valid", 64'(column_valid), 64'h0);
    check("rst_data", 64'(|column_data), 64'h0);
    check("rst_addr", 64'(|column_addr), 64'h0);
    check("rst_busy_done", 64'({busy, done}), 64'h0);
    check("rst_sent", 64'(columns_sent), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Vector table: latency to first valid, first word/address, final count.
    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].base, vecs[v].num);
      @(negedge clk);                     // cycle N+1
      check("n1_busy", 64'(busy), 64'h1);
      check("n1_done", 64'(done), 64'(vecs[v].num == '0));
      if (vecs[v].num == '0) begin
        @(negedge clk);
        check("zero_busy_after", 64'(busy), 64'h0);
        check("zero_sent", 64'(columns_sent), 64'(vecs[v].sent));
      end else begin
        @(posedge clk); @(posedge clk); @(negedge clk);   // cycle N+3
        check("n3_valid0", 64'(column_valid[0]), 64'(vecs[v].v0));
        check("n3_data0", 64'(column_data[DW-1:0]), 64'(vecs[v].d0));
        check("n3_addr0", 64'(column_addr[AW-1:0]), 64'(vecs[v].a0));
        wait_done(vecs[v].sent);
      end
    end

    // Backpressure: lane 0 stuck, column 8 must stall in FETCH.
    ready_man = 8'hFE;
    issue(12'h100, 12'd10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_stall_rd", 64'(mem_rd_en), 64'h0);
    check("bp_lane0_valid", 64'(column_valid[0]), 64'h1);
    check("bp_lane0_addr", 64'(column_addr[AW-1:0]), 64'h100);
    check("bp_lane0_data", 64'(column_data[DW-1:0]), 64'hA4A5);
    @(posedge clk); #1 ready_man = '1;
    wait_done(12'd10);

    // All eight lanes drain on one edge.
    ready_man = '0;
    issue(12'h200, 12'd8);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sim_full", 64'(column_valid), 64'hFF);
    check("sim_sent0", 64'(columns_sent), 64'h0);
    @(posedge clk); #1 ready_man = '1;
    @(posedge clk); #1 ready_man = '0;
    @(negedge clk);
    check("sim_sent8", 64'(columns_sent), 64'h8);
    check("sim_empty", 64'(column_valid), 64'h0);
    ready_man = '1;
    wait_done(12'd8);

    // start while busy is ignored.
    issue(12'h300, 12'd6);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; base_addr = 12'h555; num_columns = 12'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done(12'd6);

    // Reset mid-batch, then a fresh batch.
    issue(12'h400, 12'd10);
    repeat (4) @(posedge clk);
    #3 mon_en = 1'b0; rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 64'(mem_rd_en), 64'h0);
    check("mid_rst_rd_addr", 64'(mem_rd_addr), 64'h0);
    check("mid_rst_valid", 64'(column_valid), 64'h0);
    check("mid_rst_data", 64'(|column_data), 64'h0);
    check("mid_rst_addr", 64'(|column_addr), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_sent", 64'(columns_sent), 64'h0);
    clear_model();
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;
    issue(12'h040, 12'd5);
    wait_done(12'd5);

    // Random batches under random backpressure.
    ready_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      logic [AW-1:0] b, n;
      b = AW'($urandom_range(0, 4095));
      n = AW'($urandom_range(1, 20));
      issue(b, n);
      wait_done(n);
    end
    ready_mode = 1'b0;

    for (int k = 0; k < NU; k++) check("lane_queue_empty", 64'(lq[k].size()), 64'h0);
    check("rd_queue_empty", 64'(rdq.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
